aukv_ex_operand_stage: RTL

//  ID/EX pipeline register and operand-select stage; feeds the ALU directly.

---
 rtl/aukv_pkg.sv | 30 +++
 rtl/aukv_fwd_mux.sv | 38 +++
 rtl/aukv_ex_operand_stage.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/aukv_pkg.sv
// Shared constants for the aukv EX-side pipeline.
// ALU op encodings, widths and operand select codes.
package aukv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRA = 3'd6;
  localparam logic [2:0] ALU_SRL = 3'd7;

  localparam logic SEL_A_RS1 = 1'b0;
  localparam logic SEL_A_PC  = 1'b1;
  localparam logic SEL_B_RS2 = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  function automatic logic is_shift(
    input logic [2:0] op
  );
    return (op == ALU_SLL) ||
           (op == ALU_SRA) ||
           (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/aukv_fwd_mux.sv
// Per-source operand forwarding mux.
// x0 reads zero; MEM beats WB beats regfile.
module aukv_fwd_mux #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic [XLEN-1:0]   rf_data,
  input  logic              mem_wr_en,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]   mem_rd_data,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]   wb_rd_data,
  output logic [XLEN-1:0]   fwd_data
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = FWD_EN & mem_wr_en &
                   (mem_rd_addr == src_addr);
  assign wb_hit  = FWD_EN & wb_wr_en &
                   (wb_rd_addr == src_addr);

  // pick the youngest producer of the source
  always_comb begin
    fwd_data = rf_data;
    if (src_addr == '0)
      fwd_data = '0;
    else if (mem_hit)
      fwd_data = mem_rd_data;
    else if (wb_hit)
      fwd_data = wb_rd_data;
  end

endmodule

// File: rtl/aukv_ex_operand_stage.sv
// ID/EX register with operand select.
// Forwarding, load-use stall, flush, back-pressure.
module aukv_ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_valid,
  output logic              o_id_ready,
  input  logic [2:0]        i_id_op,
  input  logic [REG_AW-1:0] i_id_rs1_addr,
  input  logic [REG_AW-1:0] i_id_rs2_addr,
  input  logic [REG_AW-1:0] i_id_rd_addr,
  input  logic [XLEN-1:0]   i_id_rs1_data,
  input  logic [XLEN-1:0]   i_id_rs2_data,
  input  logic [XLEN-1:0]   i_id_imm,
  input  logic [XLEN-1:0]   i_id_pc,
  input  logic              i_id_sel_a,
  input  logic              i_id_sel_b,
  input  logic              i_id_wr_en,
  input  logic              i_id_is_load,
  input  logic              i_mem_wr_en,
  input  logic [REG_AW-1:0] i_mem_rd_addr,
  input  logic [XLEN-1:0]   i_mem_rd_data,
  input  logic              i_wb_wr_en,
  input  logic [REG_AW-1:0] i_wb_rd_addr,
  input  logic [XLEN-1:0]   i_wb_rd_data,
  input  logic              i_flush,
  input  logic              i_ex_ready,
  output logic              o_ex_valid,
  output logic [2:0]        o_alu_op,
  output logic [XLEN-1:0]   o_alu_a,
  output logic [XLEN-1:0]   o_alu_b,
  output logic [XLEN-1:0]   o_ex_rs2,
  output logic [REG_AW-1:0] o_ex_rd_addr,
  output logic              o_ex_wr_en,
  output logic              o_ex_is_load
);

  import aukv_pkg::*;

  logic            advance;
  logic            hazard;
  logic            transfer;
  logic            ex_hit;
  logic            mem_hit;
  logic            wb_hit;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] a_nxt;
  logic [XLEN-1:0] b_nxt;

  // rs2 always counts as used: it is store data
  function automatic logic uses(
    input logic [REG_AW-1:0] rd
  );
    return (rd != '0) &&
      (((i_id_sel_a == SEL_A_RS1) &&
        (i_id_rs1_addr == rd)) ||
       (i_id_rs2_addr == rd));
  endfunction

  aukv_fwd_mux #(
    .XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(FWD_EN)
  ) u_fwd_rs1 (
    .src_addr    (i_id_rs1_addr),
    .rf_data     (i_id_rs1_data),
    .mem_wr_en   (i_mem_wr_en),
    .mem_rd_addr (i_mem_rd_addr),
    .mem_rd_data (i_mem_rd_data),
    .wb_wr_en    (i_wb_wr_en),
    .wb_rd_addr  (i_wb_rd_addr),
    .wb_rd_data  (i_wb_rd_data),
    .fwd_data    (rs1_fwd)
  );

  aukv_fwd_mux #(
    .XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(FWD_EN)
  ) u_fwd_rs2 (
    .src_addr    (i_id_rs2_addr),
    .rf_data     (i_id_rs2_data),
    .mem_wr_en   (i_mem_wr_en),
    .mem_rd_addr (i_mem_rd_addr),
    .mem_rd_data (i_mem_rd_data),
    .wb_wr_en    (i_wb_wr_en),
    .wb_rd_addr  (i_wb_rd_addr),
    .wb_rd_data  (i_wb_rd_data),
    .fwd_data    (rs2_fwd)
  );

  assign ex_hit  = o_ex_valid & o_ex_wr_en &
                   uses(o_ex_rd_addr);
  assign mem_hit = i_mem_wr_en & uses(i_mem_rd_addr);
  assign wb_hit  = i_wb_wr_en & uses(i_wb_rd_addr);

  // without forwarding any in-flight writer stalls
  assign hazard = FWD_EN ? (ex_hit & o_ex_is_load)
                         : (ex_hit | mem_hit | wb_hit);

  assign advance    = ~o_ex_valid | i_ex_ready;
  assign o_id_ready = advance & ~hazard;
  assign transfer   = i_id_valid & o_id_ready & ~i_flush;

  // operand select; shifts only see shamt bits
  always_comb begin
    a_nxt = (i_id_sel_a == SEL_A_PC) ? i_id_pc : rs1_fwd;
    b_nxt = (i_id_sel_b == SEL_B_IMM) ? i_id_imm : rs2_fwd;
    if (is_shift(i_id_op))
      b_nxt[XLEN-1:5] = '0;
  end

  // pipeline register: load, bubble or hold
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ex_valid   <= 1'b0;
      o_alu_op     <= '0;
      o_alu_a      <= '0;
      o_alu_b      <= '0;
      o_ex_rs2     <= '0;
      o_ex_rd_addr <= '0;
      o_ex_wr_en   <= 1'b0;
      o_ex_is_load <= 1'b0;
    end else if (i_flush) begin
      o_ex_valid   <= 1'b0;
    end else if (transfer) begin
      o_ex_valid   <= 1'b1;
      o_alu_op     <= i_id_op;
      o_alu_a      <= a_nxt;
      o_alu_b      <= b_nxt;
      o_ex_rs2     <= rs2_fwd;
      o_ex_rd_addr <= i_id_rd_addr;
      o_ex_wr_en   <= i_id_wr_en;
      o_ex_is_load <= i_id_is_load;
    end else if (advance) begin
      o_ex_valid   <= 1'b0;
    end
  end

endmodule
